// File: rtl/tree_mac_accum_if.sv
// ----------------------------------------------------------------------------
// tree_mac_accum_if
//   Result bus between the MAC accumulator and the result writer.
//   Valid/ready handshake, first-word fall-through semantics on the producer.
//
//   res_out         ACC_WIDTH        completed row sum (FIFO head)
//   res_addr_i_out  ADDRESS_WIDTH_I  row tag of res_out
//   res_val         1                FIFO head is valid
//   res_rdy         1                consumer accepts the head this cycle
//
//   master : the accumulator (drives result, samples ready)
//   slave  : the result writer (samples result, drives ready)
// ----------------------------------------------------------------------------
interface tree_mac_accum_if #(
    parameter int ACC_WIDTH       = 24,
    parameter int ADDRESS_WIDTH_I = 8
);
    logic [ACC_WIDTH-1:0]       res_out;
    logic [ADDRESS_WIDTH_I-1:0] res_addr_i_out;
    logic                       res_val;
    logic                       res_rdy;

    modport master (
        output res_out,
        output res_addr_i_out,
        output res_val,
        input  res_rdy
    );

    modport slave (
        input  res_out,
        input  res_addr_i_out,
        input  res_val,
        output res_rdy
    );
endinterface

// File: rtl/tree_mac_accum.sv
// ----------------------------------------------------------------------------
// tree_mac_accum
//   Accumulates cfg_num_k consecutive k-chunks of one row (addr_i) coming from
//   the tree-adder stage into a single wide sum, then queues completed sums in
//   a small first-word fall-through FIFO towards the result writer.
//   The input has no backpressure: bad sequences and FIFO overflow are
//   reported through sticky flags instead of stalling.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   sum_in          unsigned partial sum (DATA_WIDTH)
//   addr_i_in       row tag of sum_in
//   addr_k_in       chunk index of sum_in
//   val_in          beat valid
//   cfg_num_k       chunks per row (0 behaves as 1), stable while busy
//   clr_err         clear sticky error flags (a coincident set wins)
//   res_bus         result handshake (tree_mac_accum_if.master)
//   err_seq         sticky: out-of-order / mismatched-tag beat dropped
//   err_ovf         sticky: completed result dropped on full FIFO
//   busy            a row is being accumulated
// ----------------------------------------------------------------------------
module tree_mac_accum #(
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 24,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      sum_in,
    input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
    input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
    input  logic                       val_in,
    input  logic [ADDRESS_WIDTH_K:0]   cfg_num_k,
    input  logic                       clr_err,
    tree_mac_accum_if.master           res_bus,
    output logic                       err_seq,
    output logic                       err_ovf,
    output logic                       busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                     state_reg, state_next;
    logic [ACC_WIDTH-1:0]       acc_reg, acc_next;
    logic [ADDRESS_WIDTH_K-1:0] exp_k_reg, exp_k_next;
    logic [ADDRESS_WIDTH_I-1:0] cur_i_reg, cur_i_next;
    logic                       err_seq_reg, err_ovf_reg;

    // FIFO storage is tiny and read combinationally for fall-through, so it
    // maps to distributed RAM rather than a block RAM.
    logic [ACC_WIDTH-1:0]       fifo_res_reg  [FIFO_DEPTH];
    logic [ADDRESS_WIDTH_I-1:0] fifo_addr_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;

    logic [ADDRESS_WIDTH_K:0]   num_k_eff;
    logic                       is_last;
    logic [ACC_WIDTH-1:0]       sum_ext, acc_sum;
    logic                       push, seq_err;
    logic [ACC_WIDTH-1:0]       push_res;
    logic [ADDRESS_WIDTH_I-1:0] push_addr;
    logic                       fifo_full, fifo_pop, fifo_wr, ovf_set;

    assign num_k_eff = (cfg_num_k == '0) ? (ADDRESS_WIDTH_K+1)'(1) : cfg_num_k;
    assign is_last   = ({1'b0, addr_k_in} == (num_k_eff - 1'b1));
    assign sum_ext   = ACC_WIDTH'(sum_in);
    assign acc_sum   = acc_reg + sum_ext;   // wraps modulo 2^ACC_WIDTH

    // Next-state / datapath decode
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        exp_k_next = exp_k_reg;
        cur_i_next = cur_i_reg;
        push       = 1'b0;
        push_res   = acc_sum;
        push_addr  = cur_i_reg;
        seq_err    = 1'b0;
        if (val_in) begin
            if (addr_k_in == '0) begin
                // A k=0 beat always starts a fresh row; mid-row it is a restart.
                seq_err    = (state_reg == ACCUM);
                acc_next   = sum_ext;
                cur_i_next = addr_i_in;
                exp_k_next = ADDRESS_WIDTH_K'(1);
                if (is_last) begin
                    push       = 1'b1;
                    push_res   = sum_ext;
                    push_addr  = addr_i_in;
                    state_next = IDLE;
                end else begin
                    state_next = ACCUM;
                end
            end else if (state_reg == ACCUM && addr_k_in == exp_k_reg &&
                         addr_i_in == cur_i_reg) begin
                if (is_last) begin
                    push       = 1'b1;
                    push_res   = acc_sum;
                    push_addr  = cur_i_reg;
                    acc_next   = '0;
                    state_next = IDLE;
                end else begin
                    acc_next   = acc_sum;
                    exp_k_next = exp_k_reg + 1'b1;
                end
            end else begin
                seq_err    = 1'b1;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            exp_k_reg <= '0;
            cur_i_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            exp_k_reg <= exp_k_next;
            cur_i_reg <= cur_i_next;
        end
    end

    // A push into a full FIFO still succeeds when the head leaves this cycle.
    assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_pop  = (count_reg != '0) && res_bus.res_rdy;
    assign fifo_wr   = push && (!fifo_full || fifo_pop);
    assign ovf_set   = push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_res_reg[wr_ptr_reg]  <= push_res;
            fifo_addr_reg[wr_ptr_reg] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_wr)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({fifo_wr, fifo_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky flags: a set event takes precedence over clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_seq_reg <= 1'b0;
            err_ovf_reg <= 1'b0;
        end else begin
            if (seq_err)      err_seq_reg <= 1'b1;
            else if (clr_err) err_seq_reg <= 1'b0;
            if (ovf_set)      err_ovf_reg <= 1'b1;
            else if (clr_err) err_ovf_reg <= 1'b0;
        end
    end

    assign res_bus.res_out        = fifo_res_reg[rd_ptr_reg];
    assign res_bus.res_addr_i_out = fifo_addr_reg[rd_ptr_reg];
    assign res_bus.res_val        = (count_reg != '0);
    assign err_seq                = err_seq_reg;
    assign err_ovf                = err_ovf_reg;
    assign busy                   = (state_reg == ACCUM);
endmodule
